// File: rtl/regfile_dump_if.sv
// Signal bundle between the register-file dump engine and its surroundings:
// start/abort control, register-file read port A, and the tagged output stream.
interface regfile_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, rd, out_ready,
        output ra, out_valid, out_data, out_index, out_last, busy, done
    );

    modport slave (
        output start, abort, rd, out_ready,
        input  ra, out_valid, out_data, out_index, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks read port A over registers 0..NUM_REGS-1 and
// streams each captured word with its index and a last flag over valid/ready.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic            clock,
    input  logic            reset,
    regfile_dump_if.master  bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic [ADDR_W-1:0] outIndex_q, outIndex_d;
    logic              outLast_q, outLast_d;
    logic              outValid_q, outValid_d;
    logic              done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            outData_q  <= '0;
            outIndex_q <= '0;
            outLast_q  <= 1'b0;
            outValid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            outData_q  <= outData_d;
            outIndex_q <= outIndex_d;
            outLast_q  <= outLast_d;
            outValid_q <= outValid_d;
            done_q     <= done_d;
        end
    end

    // Abort beats both a pending handshake and a start; the cancelled word is dropped.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        outData_d  = outData_q;
        outIndex_d = outIndex_q;
        outLast_d  = outLast_q;
        outValid_d = outValid_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    outValid_d = 1'b0;
                end else begin
                    outData_d  = bus.rd;
                    outIndex_d = idx_q;
                    outLast_d  = (idx_q == LAST_IDX);
                    outValid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    outValid_d = 1'b0;
                end else if (outValid_q && bus.out_ready) begin
                    outValid_d = 1'b0;
                    if (outLast_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                idx_d      = '0;
                outValid_d = 1'b0;
            end
        endcase
    end

    // idx rests at 0 whenever the engine is idle, so it can drive the read address directly.
    assign bus.ra        = idx_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign bus.out_index = outIndex_q;
    assign bus.out_last  = outLast_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a behavioural register file feeds read port A,
// expected words are queued per accepted start and a negedge monitor pops and compares them.
module tb_regfile_dump;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 400;

    typedef struct {
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] regs  [NUM_REGS];
    logic [DATA_W-1:0] model [NUM_REGS];
    logic              wen   = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [DATA_W-1:0] wdata = '0;
    int                nChecks = 0;
    int                nFails  = 0;
    int                cycle   = 0;
    word_t             sb[$];

    word_t             monWord;
    logic              handshake;
    logic              expDone  = 1'b0;
    logic              prevHold = 1'b0;
    word_t             prevWord;

    regfile_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Register file stand-in: combinational read, write on the falling edge.
    assign bus.rd = regs[bus.ra];
    always @(negedge clock) if (wen) regs[waddr] <= wdata;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        bus.start     = s;
        bus.abort     = a;
        bus.out_ready = r;
    endtask

    // Every accepted start yields registers 0..NUM_REGS-1 in order, last flag on the final one.
    task automatic pushDump();
        word_t w;
        for (int i = 0; i < NUM_REGS; i++) begin
            w.index = ADDR_W'(i);
            w.data  = model[i];
            w.last  = (i == NUM_REGS - 1);
            sb.push_back(w);
        end
    endtask

    task automatic writeReg(input int a, input logic [DATA_W-1:0] d);
        @(posedge clock);
        #1 wen = 1'b1; waddr = ADDR_W'(a); wdata = d; model[a] = d;
        @(negedge clock);
        #1 wen = 1'b0;
    endtask

    task automatic startDump(output int when);
        @(posedge clock);
        #1 bus.start = 1'b1;
        @(posedge clock);
        #1 when = cycle;
        bus.start = 1'b0;
        pushDump();
    endtask

    task automatic waitWord(input int idx);
        bit found = 1'b0;
        for (int n = 0; n < TIMEOUT && !found; n++) begin
            @(negedge clock);
            found = bus.out_valid && (bus.out_index == ADDR_W'(idx));
        end
        nChecks++;
        if (!found) begin
            nFails++;
            $display("[TB] FAIL waitWord: index %0d never presented, expected it within %0d cycles", idx, TIMEOUT);
        end
    endtask

    task automatic waitDone(output int when);
        bit found = 1'b0;
        for (int n = 0; n < TIMEOUT && !found; n++) begin
            @(negedge clock);
            found = bus.done;
        end
        when = cycle;
        nChecks++;
        if (!found) begin
            nFails++;
            $display("[TB] FAIL waitDone: done=0 after %0d cycles, expected a done pulse", TIMEOUT);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, DATA_W'(bus.out_valid), '0);
        checkOutput({tag, "_busy"},  DATA_W'(bus.busy),      '0);
        checkOutput({tag, "_done"},  DATA_W'(bus.done),      '0);
        checkOutput({tag, "_ra"},    DATA_W'(bus.ra),        '0);
    endtask

    // Monitor: compares each accepted word, done timing and stability under backpressure.
    always @(negedge clock) begin
        if (reset) begin
            expDone  = 1'b0;
            prevHold = 1'b0;
        end else begin
            checkOutput("done", DATA_W'(bus.done), DATA_W'(expDone));
            if (prevHold) begin
                checkOutput("holdValid", DATA_W'(bus.out_valid), 1);
                checkOutput("holdData",  bus.out_data,           prevWord.data);
                checkOutput("holdIndex", DATA_W'(bus.out_index), DATA_W'(prevWord.index));
                checkOutput("holdLast",  DATA_W'(bus.out_last),  DATA_W'(prevWord.last));
            end
            handshake = bus.out_valid && bus.out_ready && !bus.abort;
            expDone   = 1'b0;
            if (handshake) begin
                nChecks++;
                if (sb.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL unexpectedWord: got index %0d data 0x%0h, expected no word",
                             bus.out_index, bus.out_data);
                end else begin
                    monWord = sb.pop_front();
                    checkOutput("wordIndex", DATA_W'(bus.out_index), DATA_W'(monWord.index));
                    checkOutput("wordData",  bus.out_data,           monWord.data);
                    checkOutput("wordLast",  DATA_W'(bus.out_last),  DATA_W'(monWord.last));
                    expDone = monWord.last;
                end
            end
            prevHold       = bus.out_valid && !bus.out_ready && !bus.abort;
            prevWord.index = bus.out_index;
            prevWord.data  = bus.out_data;
            prevWord.last  = bus.out_last;
        end
    end

    initial begin
        int t0;
        int t1;
        bit found;

        applyStimulus(1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #6;
        checkIdleOutputs("reset");
        checkOutput("reset_data",  bus.out_data,            '0);
        checkOutput("reset_index", DATA_W'(bus.out_index), '0);
        checkOutput("reset_last",  DATA_W'(bus.out_last),  '0);
        #5 reset = 1'b0;

        // Directed pattern, full-speed consumer.
        for (int i = 0; i < NUM_REGS; i++) writeReg(i, 32'hA5A5_0000 + DATA_W'(i));
        applyStimulus(1'b0, 1'b0, 1'b1);
        startDump(t0);
        waitDone(t1);
        checkOutput("fullDumpLatency", DATA_W'(t1 - t0), 64);

        // Backpressure on index 3, then a negedge write to R7 just before its read.
        startDump(t0);
        waitWord(2);
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput("bpValid", DATA_W'(bus.out_valid), 1);
        checkOutput("bpIndex", DATA_W'(bus.out_index), 3);
        checkOutput("bpData",  bus.out_data,           32'hA5A5_0003);
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
        waitWord(6);
        @(posedge clock);
        #1 wen = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; model[7] = 32'h1234_5678;
        foreach (sb[k]) if (sb[k].index == 5'd7) sb[k].data = 32'h1234_5678;
        @(negedge clock);
        #1 wen = 1'b0;
        waitDone(t1);

        // Abort during SEND of index 10 together with a ready consumer.
        startDump(t0);
        waitWord(9);
        @(posedge clock);
        @(posedge clock);
        #1 bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        sb.delete();
        @(negedge clock);
        checkIdleOutputs("abort");
        repeat (3) @(negedge clock);
        checkOutput("abortStaysIdle", DATA_W'(bus.busy), 0);
        startDump(t0);
        waitDone(t1);
        checkOutput("restartLatency", DATA_W'(t1 - t0), 64);

        // Start held through a dump and into the done cycle: exactly two dumps.
        @(posedge clock);
        #1 bus.start = 1'b1;
        @(posedge clock);
        #1 t0 = cycle;
        pushDump();
        waitDone(t1);
        checkOutput("heldStartLatency", DATA_W'(t1 - t0), 64);
        @(posedge clock);
        #1 t0 = cycle;
        bus.start = 1'b0;
        pushDump();
        waitDone(t1);
        checkOutput("secondStartLatency", DATA_W'(t1 - t0), 64);
        repeat (4) @(negedge clock);
        checkIdleOutputs("afterHeld");

        // Random contents with a randomly stalling consumer.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REGS; i++) writeReg(i, DATA_W'($urandom));
            startDump(t0);
            found = 1'b0;
            for (int n = 0; n < 4 * TIMEOUT && !found; n++) begin
                @(posedge clock);
                #1 bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge clock);
                found = bus.done;
            end
            nChecks++;
            if (!found) begin
                nFails++;
                $display("[TB] FAIL randomDump%0d: done=0 after %0d cycles, expected a done pulse", r, 4 * TIMEOUT);
            end
            #1 bus.out_ready = 1'b1;
        end

        // Asynchronous reset in the middle of SEND for index 15.
        bus.out_ready = 1'b1;
        startDump(t0);
        waitWord(14);
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checkIdleOutputs("midReset");
        checkOutput("midReset_data",  bus.out_data,           '0);
        checkOutput("midReset_index", DATA_W'(bus.out_index), '0);
        checkOutput("midReset_last",  DATA_W'(bus.out_last),  '0);
        sb.delete();
        @(negedge clock);
        #2 reset = 1'b0;
        bus.out_ready = 1'b1;
        startDump(t0);
        waitDone(t1);
        checkOutput("postResetLatency", DATA_W'(t1 - t0), 64);

        // Abort together with start in IDLE keeps the engine idle.
        @(posedge clock);
        #1 applyStimulus(1'b1, 1'b1, 1'b1);
        @(posedge clock);
        #1 applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        checkIdleOutputs("abortStart");

        repeat (3) @(negedge clock);
        checkOutput("sbDrained", DATA_W'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the 32×32 register file. On a start pulse it walks register-file read port A from address 0 to NUM_REGS-1. It captures each word and streams it out over a valid/ready interface, tagged with its index and a last flag. It sits beside the datapath, shares read port A through the core's debug mux, and is read by the debug/trace unit.

## Interface
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1); legal range 2..32.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns the engine to IDLE.
- ra  out  ADDR_W  register-file read address (drives raA through the debug mux).
- rd  in  DATA_W  register-file read data (combinational from ra).
- out_valid  out  1  out_data/out_index/out_last hold a word.
- out_ready  in  1  consumer accepts the word when high with out_valid.
- out_data  out  DATA_W  captured register value.
- out_index  out  ADDR_W  register index of out_data.
- out_last  out  1  high with out_valid on index NUM_REGS-1.
- busy  out  1  high in READ and SEND.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE: ra=0, busy=0, out_valid=0. start=1 → READ with idx=0.
  - READ: ra=idx. At posedge, capture rd into out_data and idx into out_index, set out_valid=1 and out_last=(idx==NUM_REGS-1), then → SEND.
  - SEND: hold all out_* outputs stable. On out_valid&&out_ready:
    - if out_last: out_valid←0, done←1, → IDLE.
    - otherwise: idx←idx+1, out_valid←0, → READ.
- out_data, out_index and out_last must not change while out_valid=1 and out_ready=0.
- The register file writes on negedge, so the word captured at a posedge includes any write from the preceding negedge. The dump is per-word, not an atomic snapshot; the core is expected to be stalled during a dump.
- abort=1 in READ or SEND at posedge:
  - → IDLE, out_valid←0, idx←0, done stays 0.
  - abort wins over a simultaneous handshake; that word counts as not transferred.
- abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins and the engine stays in IDLE.
- start while busy is ignored; it is not queued.
- idx never exceeds NUM_REGS-1. There is no wrap-around; after the last word the engine returns to IDLE.
- Reset (asynchronous, any state): state=IDLE, idx=0, ra=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.

## Timing
- start high at edge T → busy=1 and ra=0 after T.
- Word 0 captured at T+1; out_valid=1 after T+1.
- Each word costs 1 READ cycle plus ≥1 SEND cycle. With out_ready held at 1 the engine produces one word every 2 cycles, and a full 32-word dump takes 64 cycles from start to the last accept.
- The last accept at edge E gives done=1 for cycle E..E+1 and busy=0 after E.
- A new start is accepted at E+1 or later.
- ra changes only at posedge. rd is assumed settled within the same cycle.
- No combinational path from out_ready to any output.

## Test plan
- Preload R[i]=0xA5A50000+i; start with out_ready=1 → 32 words with out_index 0..31 and out_data 0xA5A50000..0xA5A5001F. out_last appears only on index 31. done pulses once, 64 cycles after start.
- Backpressure: out_ready=0 for 5 cycles on index 3 → out_valid stays 1 and out_data=0xA5A50003 stays stable. Index 4 follows only after the accept, with no word lost or duplicated.
- Write R7=0x12345678 via wen on the negedge just before the READ edge of index 7 → out_data=0x12345678 for index 7.
- abort asserted in SEND of index 10 together with out_ready=1 → out_valid=0 next cycle, busy=0, no done. A new start dumps from index 0 again.
- start held high during a dump and again on the done cycle → exactly one dump per accepted start. There is no restart while busy.
- Assert reset mid-SEND (index 15) between clock edges → all outputs 0 immediately. After release, IDLE accepts start normally.
